// File: rtl/serial_console_port.sv
// Device-side byte-serial console endpoint: buffered 8N1 UART transmitter plus
// a receiver feeding a one-byte holding register for the processor.
module serial_console_port #(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter int unsigned TX_DEPTH     = 8
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] wr_data,
    input  logic       wr_en,
    output logic       wr_ready,
    input  logic       rd_en,
    output logic [7:0] rd_data,
    output logic       rd_valid,
    input  logic       uart_rx,
    output logic       uart_tx,
    output logic       tx_busy,
    output logic       rx_overrun,
    output logic       rx_frame_err
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned PTR_W = $clog2(TX_DEPTH);
    localparam int unsigned OCC_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_END = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(TX_DEPTH);

    typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} state_t;

    // ---------------- TX FIFO ----------------
    logic [7:0]       r_mem [TX_DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [OCC_W-1:0] r_count;
    logic [OCC_W-1:0] w_count_next;
    logic             r_wr_ready;
    logic             w_push;
    logic             w_pop;

    assign w_push       = wr_en && r_wr_ready;
    assign w_count_next = r_count + OCC_W'(w_push) - OCC_W'(w_pop);

    always_ff @(posedge clock) begin
        if (w_push) r_mem[r_wptr] <= wr_data;
    end

    // wr_ready is registered from the next occupancy so it tracks !full exactly
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_wr_ready <= 1'b1;
        end else begin
            if (w_push) r_wptr <= r_wptr + PTR_W'(1);
            if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
            r_count    <= w_count_next;
            r_wr_ready <= (w_count_next != OCC_FULL);
        end
    end

    // ---------------- TX FSM ----------------
    state_t           r_tx_state, w_tx_state_next;
    logic [CNT_W-1:0] r_tx_cnt, w_tx_cnt_next;
    logic [2:0]       r_tx_bit, w_tx_bit_next;
    logic [7:0]       r_tx_shift, w_tx_shift_next;
    logic             r_uart_tx;
    logic             r_tx_busy;

    always_comb begin
        w_tx_state_next = r_tx_state;
        w_tx_cnt_next   = r_tx_cnt;
        w_tx_bit_next   = r_tx_bit;
        w_tx_shift_next = r_tx_shift;
        w_pop           = 1'b0;
        case (r_tx_state)
            ST_IDLE: begin
                if (r_count != '0) begin
                    w_pop           = 1'b1;
                    w_tx_shift_next = r_mem[r_rptr];
                    w_tx_cnt_next   = '0;
                    w_tx_state_next = ST_START;
                end
            end
            ST_START: begin
                if (r_tx_cnt == BIT_END) begin
                    w_tx_cnt_next   = '0;
                    w_tx_bit_next   = '0;
                    w_tx_state_next = ST_DATA;
                end else begin
                    w_tx_cnt_next = r_tx_cnt + CNT_W'(1);
                end
            end
            ST_DATA: begin
                if (r_tx_cnt == BIT_END) begin
                    w_tx_cnt_next   = '0;
                    w_tx_shift_next = {1'b0, r_tx_shift[7:1]};
                    if (r_tx_bit == 3'd7) w_tx_state_next = ST_STOP;
                    else                  w_tx_bit_next   = r_tx_bit + 3'd1;
                end else begin
                    w_tx_cnt_next = r_tx_cnt + CNT_W'(1);
                end
            end
            ST_STOP: begin
                // Chain straight into the next start bit when more data is queued
                if (r_tx_cnt == BIT_END) begin
                    w_tx_cnt_next = '0;
                    if (r_count != '0) begin
                        w_pop           = 1'b1;
                        w_tx_shift_next = r_mem[r_rptr];
                        w_tx_state_next = ST_START;
                    end else begin
                        w_tx_state_next = ST_IDLE;
                    end
                end else begin
                    w_tx_cnt_next = r_tx_cnt + CNT_W'(1);
                end
            end
            default: w_tx_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_tx_state <= ST_IDLE;
            r_tx_cnt   <= '0;
            r_tx_bit   <= '0;
            r_tx_shift <= '0;
            r_uart_tx  <= 1'b1;
            r_tx_busy  <= 1'b0;
        end else begin
            r_tx_state <= w_tx_state_next;
            r_tx_cnt   <= w_tx_cnt_next;
            r_tx_bit   <= w_tx_bit_next;
            r_tx_shift <= w_tx_shift_next;
            case (r_tx_state)
                ST_START: r_uart_tx <= 1'b0;
                ST_DATA:  r_uart_tx <= r_tx_shift[0];
                default:  r_uart_tx <= 1'b1;
            endcase
            r_tx_busy  <= (r_tx_state != ST_IDLE) || (r_count != '0);
        end
    end

    // ---------------- RX synchronizer and FSM ----------------
    logic             r_rx_meta, r_rx_sync;
    state_t           r_rx_state, w_rx_state_next;
    logic [CNT_W-1:0] r_rx_cnt, w_rx_cnt_next;
    logic [2:0]       r_rx_bit, w_rx_bit_next;
    logic [7:0]       r_rx_shift, w_rx_shift_next;
    logic             w_deliver;
    logic             w_frame_bad;

    always_comb begin
        w_rx_state_next = r_rx_state;
        w_rx_cnt_next   = r_rx_cnt;
        w_rx_bit_next   = r_rx_bit;
        w_rx_shift_next = r_rx_shift;
        w_deliver       = 1'b0;
        w_frame_bad     = 1'b0;
        case (r_rx_state)
            ST_IDLE: begin
                if (!r_rx_sync) begin
                    w_rx_cnt_next   = '0;
                    w_rx_state_next = ST_START;
                end
            end
            ST_START: begin
                // Mid start bit: still low means a real frame, otherwise a glitch
                if (r_rx_cnt == HALF_END) begin
                    w_rx_cnt_next   = '0;
                    w_rx_bit_next   = '0;
                    w_rx_state_next = r_rx_sync ? ST_IDLE : ST_DATA;
                end else begin
                    w_rx_cnt_next = r_rx_cnt + CNT_W'(1);
                end
            end
            ST_DATA: begin
                if (r_rx_cnt == BIT_END) begin
                    w_rx_cnt_next   = '0;
                    w_rx_shift_next = {r_rx_sync, r_rx_shift[7:1]};
                    if (r_rx_bit == 3'd7) w_rx_state_next = ST_STOP;
                    else                  w_rx_bit_next   = r_rx_bit + 3'd1;
                end else begin
                    w_rx_cnt_next = r_rx_cnt + CNT_W'(1);
                end
            end
            ST_STOP: begin
                if (r_rx_cnt == BIT_END) begin
                    w_rx_cnt_next   = '0;
                    w_deliver       = r_rx_sync;
                    w_frame_bad     = !r_rx_sync;
                    w_rx_state_next = ST_IDLE;
                end else begin
                    w_rx_cnt_next = r_rx_cnt + CNT_W'(1);
                end
            end
            default: w_rx_state_next = ST_IDLE;
        endcase
    end

    logic [7:0] r_rd_data;
    logic       r_rd_valid;
    logic       r_rx_overrun;
    logic       r_rx_frame_err;

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_rx_meta      <= 1'b1;
            r_rx_sync      <= 1'b1;
            r_rx_state     <= ST_IDLE;
            r_rx_cnt       <= '0;
            r_rx_bit       <= '0;
            r_rx_shift     <= '0;
            r_rd_data      <= 8'h00;
            r_rd_valid     <= 1'b0;
            r_rx_overrun   <= 1'b0;
            r_rx_frame_err <= 1'b0;
        end else begin
            r_rx_meta  <= uart_rx;
            r_rx_sync  <= r_rx_meta;
            r_rx_state <= w_rx_state_next;
            r_rx_cnt   <= w_rx_cnt_next;
            r_rx_bit   <= w_rx_bit_next;
            r_rx_shift <= w_rx_shift_next;
            // A read in the delivery cycle frees the slot for the new byte
            if (w_deliver) begin
                if (!r_rd_valid || rd_en) begin
                    r_rd_data  <= r_rx_shift;
                    r_rd_valid <= 1'b1;
                end else begin
                    r_rx_overrun <= 1'b1;
                end
            end else if (rd_en && r_rd_valid) begin
                r_rd_valid <= 1'b0;
            end
            if (w_frame_bad) r_rx_frame_err <= 1'b1;
        end
    end

    assign wr_ready     = r_wr_ready;
    assign uart_tx      = r_uart_tx;
    assign tx_busy      = r_tx_busy;
    assign rd_data      = r_rd_data;
    assign rd_valid     = r_rd_valid;
    assign rx_overrun   = r_rx_overrun;
    assign rx_frame_err = r_rx_frame_err;

endmodule

// File: tb/tb_serial_console_port.sv
// Directed bench for serial_console_port at 4 clocks per bit, 8-deep TX FIFO.
module tb_serial_console_port;

    localparam int unsigned CPB   = 4;
    localparam int unsigned DEPTH = 8;

    logic       clock = 1'b0;
    logic       reset;
    logic [7:0] wr_data;
    logic       wr_en;
    logic       wr_ready;
    logic       rd_en;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       tb_rx;
    logic       loop_en;
    logic       uart_rx_w;
    logic       uart_tx;
    logic       tx_busy;
    logic       rx_overrun;
    logic       rx_frame_err;

    int total = 0;
    int bad   = 0;

    assign uart_rx_w = loop_en ? uart_tx : tb_rx;

    always #5 clock = ~clock;

    serial_console_port #(.CLKS_PER_BIT(CPB), .TX_DEPTH(DEPTH)) dut (
        .clock(clock), .reset(reset),
        .wr_data(wr_data), .wr_en(wr_en), .wr_ready(wr_ready),
        .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid),
        .uart_rx(uart_rx_w), .uart_tx(uart_tx), .tx_busy(tx_busy),
        .rx_overrun(rx_overrun), .rx_frame_err(rx_frame_err)
    );

    typedef struct {
        logic [7:0] data;
        logic       stop_ok;
        logic       rd_after;
        logic       exp_valid;
        logic [7:0] exp_data;
        logic       exp_ovr;
        logic       exp_ferr;
    } rx_vec_t;

    rx_vec_t vecs [4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one frame starting at the next edge; returns at the negedge after the stop bit
    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        tb_rx = 1'b0;
        repeat (CPB) @(negedge clock);
        for (int i = 0; i < 8; i++) begin
            tb_rx = b[i];
            repeat (CPB) @(negedge clock);
        end
        tb_rx = stop_bit;
        repeat (CPB) @(negedge clock);
        tb_rx = 1'b1;
    endtask

    // Expected line level for 9 back-to-back frames 0x30..0x38, m = cycles since first start
    function automatic logic burst_exp(input int m);
        logic [7:0] v;
        int j, p;
        if (m < 0 || m >= 360) return 1'b1;
        j = m / 40;
        p = m % 40;
        if (p < 4) return 1'b0;
        v = 8'(8'h30 + j);
        if (p < 36) return v[(p - 4) / 4];
        return 1'b1;
    endfunction

    initial begin
        logic [7:0] b;
        logic       e;
        int         waited;

        vecs[0] = '{8'h5A, 1'b1, 1'b1, 1'b1, 8'h5A, 1'b0, 1'b0};
        vecs[1] = '{8'h41, 1'b1, 1'b0, 1'b1, 8'h41, 1'b0, 1'b0};
        vecs[2] = '{8'h42, 1'b1, 1'b1, 1'b1, 8'h41, 1'b1, 1'b0};
        vecs[3] = '{8'h99, 1'b0, 1'b0, 1'b0, 8'h41, 1'b1, 1'b1};

        reset = 1'b0; wr_en = 1'b0; rd_en = 1'b0; wr_data = 8'h00;
        tb_rx = 1'b1; loop_en = 1'b0;
        repeat (3) @(negedge clock);
        check("rst_uart_tx", 32'(uart_tx), 32'd1);
        check("rst_wr_ready", 32'(wr_ready), 32'd1);
        check("rst_rd_valid", 32'(rd_valid), 32'd0);
        check("rst_rd_data", 32'(rd_data), 32'h00);
        check("rst_tx_busy", 32'(tx_busy), 32'd0);
        check("rst_overrun", 32'(rx_overrun), 32'd0);
        check("rst_frame_err", 32'(rx_frame_err), 32'd0);
        reset = 1'b1;
        @(negedge clock);

        // Single frame 0x48: start low at N+2, busy drops at N+42
        b = 8'h48;
        wr_data = b; wr_en = 1'b1;
        @(negedge clock);
        wr_en = 1'b0;
        for (int k = 1; k <= 42; k++) begin
            @(negedge clock);
            if (k < 2)       e = 1'b1;
            else if (k < 6)  e = 1'b0;
            else if (k < 38) e = b[(k - 6) / 4];
            else             e = 1'b1;
            if (k <= 41) check($sformatf("tx48_k%0d", k), 32'(uart_tx), 32'(e));
            if (k == 41) check("tx48_busy_hold", 32'(tx_busy), 32'd1);
            if (k == 42) check("tx48_busy_drop", 32'(tx_busy), 32'd0);
        end

        // Ten consecutive writes: nine accepted, 0x39 dropped, frames back-to-back
        for (int k = 0; k <= 373; k++) begin
            if (k < 10) begin
                wr_data = 8'(8'h30 + k);
                wr_en   = 1'b1;
                check($sformatf("ovf_ready_%0d", k), 32'(wr_ready), (k < 9) ? 32'd1 : 32'd0);
            end else begin
                wr_en = 1'b0;
            end
            check($sformatf("burst_k%0d", k), 32'(uart_tx), 32'(burst_exp(k - 3)));
            @(negedge clock);
        end
        check("burst_busy_end", 32'(tx_busy), 32'd0);

        // One-cycle low glitch must be rejected silently
        tb_rx = 1'b0;
        @(negedge clock);
        tb_rx = 1'b1;
        repeat (10) @(negedge clock);
        check("glitch_valid", 32'(rd_valid), 32'd0);
        check("glitch_overrun", 32'(rx_overrun), 32'd0);
        check("glitch_frame_err", 32'(rx_frame_err), 32'd0);

        // Delivery coinciding with a read replaces the byte without overrun
        send_frame(8'h11, 1'b1);
        repeat (2) @(negedge clock);
        check("same_first_valid", 32'(rd_valid), 32'd1);
        check("same_first_data", 32'(rd_data), 32'h11);
        repeat (8) @(negedge clock);
        send_frame(8'h22, 1'b1);
        rd_en = 1'b1;
        @(negedge clock);
        rd_en = 1'b0;
        check("same_valid", 32'(rd_valid), 32'd1);
        check("same_data", 32'(rd_data), 32'h22);
        check("same_overrun", 32'(rx_overrun), 32'd0);
        @(negedge clock);
        check("same_valid_hold", 32'(rd_valid), 32'd1);
        rd_en = 1'b1;
        @(negedge clock);
        rd_en = 1'b0;
        check("same_cleared", 32'(rd_valid), 32'd0);
        repeat (4) @(negedge clock);

        // Receive table: delivery, overrun, framing error
        for (int i = 0; i < 4; i++) begin
            send_frame(vecs[i].data, vecs[i].stop_ok);
            repeat (2) @(negedge clock);
            check($sformatf("rx%0d_valid", i), 32'(rd_valid), 32'(vecs[i].exp_valid));
            check($sformatf("rx%0d_data", i), 32'(rd_data), 32'(vecs[i].exp_data));
            check($sformatf("rx%0d_overrun", i), 32'(rx_overrun), 32'(vecs[i].exp_ovr));
            check($sformatf("rx%0d_frame_err", i), 32'(rx_frame_err), 32'(vecs[i].exp_ferr));
            if (vecs[i].rd_after) begin
                rd_en = 1'b1;
                @(negedge clock);
                rd_en = 1'b0;
                check($sformatf("rx%0d_read_clr", i), 32'(rd_valid), 32'd0);
                check($sformatf("rx%0d_read_data", i), 32'(rd_data), 32'(vecs[i].exp_data));
            end
            repeat (8) @(negedge clock);
        end

        // Reset in the middle of the data bits of 0x55
        wr_data = 8'h55; wr_en = 1'b1;
        @(negedge clock);
        wr_en = 1'b0;
        repeat (10) @(negedge clock);
        check("mid_pre_tx", 32'(uart_tx), 32'd0);
        reset = 1'b0;
        @(negedge clock);
        check("mid_uart_tx", 32'(uart_tx), 32'd1);
        check("mid_busy", 32'(tx_busy), 32'd0);
        check("mid_wr_ready", 32'(wr_ready), 32'd1);
        check("mid_rd_valid", 32'(rd_valid), 32'd0);
        check("mid_overrun", 32'(rx_overrun), 32'd0);
        check("mid_frame_err", 32'(rx_frame_err), 32'd0);
        reset = 1'b1;
        repeat (6) @(negedge clock);
        check("mid_after_tx", 32'(uart_tx), 32'd1);
        check("mid_after_busy", 32'(tx_busy), 32'd0);

        // Loopback round trip of 0xA5
        loop_en = 1'b1;
        @(negedge clock);
        wr_data = 8'hA5; wr_en = 1'b1;
        @(negedge clock);
        wr_en = 1'b0;
        waited = 0;
        while (!rd_valid && waited < 100) begin
            @(negedge clock);
            waited++;
        end
        check("loop_valid", 32'(rd_valid), 32'd1);
        check("loop_data", 32'(rd_data), 32'hA5);
        check("loop_frame_err", 32'(rx_frame_err), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/serial_console_port.md
Name: serial_console_port

Overview:
Device-side endpoint of the processor's byte-serial I/O interface. It accepts bytes the processor writes (serial_out/serial_wren_out), buffers them in a TX FIFO, and serializes them as 8N1 UART frames. It also deserializes incoming UART frames into a one-byte holding register that the processor consumes via serial_rden_out. It sits between the processor top and the board UART pins, replacing the tied-off serial inputs used in free-run simulation.

Parameters:
CLKS_PER_BIT, 434, clock cycles per UART bit (50 MHz / 115200); minimum 4.
TX_DEPTH, 8, TX FIFO entries; power of two, minimum 2.

Ports:
clock  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-low reset
wr_data  input  8  byte from processor (serial_out)
wr_en  input  1  write strobe from processor (serial_wren_out)
wr_ready  output  1  TX FIFO can accept a byte (to serial_ready_in)
rd_en  input  1  processor consumes received byte (serial_rden_out)
rd_data  output  8  received byte (to serial_in)
rd_valid  output  1  rd_data holds an unread byte (to serial_valid_in)
uart_rx  input  1  asynchronous serial input, idle high
uart_tx  output  1  serial output, idle high
tx_busy  output  1  TX FSM not IDLE or FIFO non-empty
rx_overrun  output  1  sticky: received byte dropped because rd_valid was still set
rx_frame_err  output  1  sticky: stop bit sampled low

Behaviour:
- Reset (reset=0 at a rising edge): uart_tx=1, wr_ready=1, rd_valid=0, rd_data=8'h00, tx_busy=0, rx_overrun=0, rx_frame_err=0. FIFO emptied, both FSMs to IDLE, counters cleared. Reset mid-frame aborts immediately. uart_tx is high after that edge. Partial bytes are lost.
- TX FIFO: write accepted when wr_en=1 and wr_ready=1. wr_ready = !full, derived from the occupancy count. It is not relieved by a same-cycle pop. A write while full is silently dropped, with no flag. A simultaneous push and pop leaves the count unchanged. Pointers wrap modulo TX_DEPTH.
- TX FSM states: IDLE, START, DATA, STOP.
  - IDLE: if FIFO non-empty, pop into the shift register and enter START.
  - START: uart_tx=0 for CLKS_PER_BIT cycles.
  - DATA: 8 bits, LSB first, CLKS_PER_BIT cycles each.
  - STOP: uart_tx=1 for CLKS_PER_BIT cycles.
  - At the end of STOP: if FIFO non-empty, pop and go directly to START (no idle gap); otherwise go to IDLE.
- TX latency: with an empty FIFO and FSM in IDLE, a write sampled at edge N makes the byte visible at N+1. The pop occurs at N+1, and uart_tx falls at edge N+2. A frame is exactly 10*CLKS_PER_BIT cycles. uart_tx is driven from a register.
- Capacity: the shift register plus the FIFO hold TX_DEPTH+1 bytes while transmitting.
- RX sync: uart_rx passes through a 2-flop synchronizer before use. A falling edge of the synchronized input is seen in IDLE.
- RX FSM states: IDLE, START, DATA, STOP.
  - IDLE → START on a low level.
  - START: wait CLKS_PER_BIT/2 cycles, then resample. Low → DATA; high → IDLE (glitch rejected, no flags).
  - DATA: sample every CLKS_PER_BIT cycles at bit centre, 8 bits, LSB first.
  - STOP: sample one bit period later. High → deliver the byte. Low → discard the byte, set rx_frame_err. Either way → IDLE. No wait for line idle.
- Holding register and delivery:
  - Delivery with rd_valid=0: rd_data ← byte, rd_valid ← 1 at that edge.
  - rd_en=1 with rd_valid=1: rd_valid ← 0 at the next edge. rd_data holds its value.
  - rd_en with rd_valid=0 is ignored.
  - Delivery with rd_valid=1 and rd_en=0: new byte dropped, rd_data unchanged, rx_overrun ← 1.
  - Delivery in the same cycle as rd_en=1 with rd_valid=1: rd_data ← new byte, rd_valid stays 1, no overrun.
- rx_overrun and rx_frame_err clear only on reset.
- TX and RX are fully independent. Loopback (uart_tx tied to uart_rx) must round-trip bytes.

Test Plan:
- All scenarios use CLKS_PER_BIT=4 and TX_DEPTH=8 unless noted.
- Reset: hold reset=0 for 3 cycles with uart_rx=1 → uart_tx=1, wr_ready=1, rd_valid=0, rd_data=00, tx_busy=0, both flags 0.
- Single TX: write 0x48 at edge N → uart_tx=0 from N+2 for 4 cycles, then bits 0,0,0,1,0,0,1,0 (4 cycles each), then high. tx_busy deasserts at N+42.
- Overflow: write 0x30..0x39 on 10 consecutive edges from an empty, idle state → first 9 accepted. wr_ready=0 at the 10th, and 0x39 is dropped. 9 frames 0x30..0x38 are emitted back-to-back, 360 cycles with no high gap between stop and start.
- RX delivery: drive frame 0x5A on uart_rx → rd_valid=1, rd_data=5A ~2 cycles after stop-bit centre. Pulse rd_en → rd_valid=0 next edge.
- RX errors:
  - Frames 0x41 then 0x42 with no rd_en → rd_data=41, rx_overrun=1.
  - A frame with stop bit low → rd_valid unchanged, rx_frame_err=1.
  - A 1-cycle low glitch → no flags, no byte.
- Reset mid-frame and loopback:
  - Assert reset during the DATA bits of 0x55 → uart_tx=1 after that edge, FIFO empty, tx_busy=0.
  - With uart_tx looped to uart_rx, write 0xA5 → rd_data=A5, rd_valid=1.
